// File: rtl/data_stack_pkg.sv
// Shared opcode and FSM-state encodings for the data stack, and a helper that sizes
// the RAM address bus.
package data_stack_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_DUP     = 3'd3;
    localparam logic [2:0] OP_SWAP    = 3'd4;
    localparam logic [2:0] OP_REPLACE = 3'd5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_POP_RD  = 2'd1;
    localparam logic [1:0] ST_SWAP_RD = 2'd2;

    // A one-word RAM still needs a 1-bit address bus.
    function automatic int unsigned ram_addr_w(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous RAM that holds every stack entry below TOS.
// It has a registered read port with 1-cycle latency, and it maps onto block RAM.
module stack_ram
    import data_stack_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WORDS = 255,
    parameter int unsigned AW    = ram_addr_w(WORDS)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:WORDS-1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_stack.sv
// Parametrised CPU data stack: TOS lives in a register and deeper cells live in stack_ram.
// Defining the macro DATA_STACK_HWM_EN enables the high-water-mark register.
module data_stack
    import data_stack_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [WIDTH-1:0]           cmd_data,
    output logic [WIDTH-1:0]           tos,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       err_overflow,
    output logic                       err_underflow,
    input  logic                       err_clr,
    output logic [$clog2(DEPTH+1)-1:0] hwm
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = ram_addr_w(DEPTH - 1);

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] tos_n;
    logic [DW-1:0]    depth_n, depth_m1, depth_m2;
    logic             fire, nos_ok, set_ovf, set_unf;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata, ram_rdata;

    assign cmd_ready = (state == ST_IDLE);
    assign fire      = cmd_valid && cmd_ready;
    assign empty     = (depth == '0);
    assign full      = (depth == DW'(DEPTH));
    assign nos_ok    = (depth >= DW'(2));
    assign depth_m1  = depth - DW'(1);
    assign depth_m2  = depth - DW'(2);

    stack_ram #(.WIDTH(WIDTH), .WORDS(DEPTH - 1), .AW(AW)) u_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // NOS sits at RAM[depth-2], and a push spills TOS into RAM[depth-1].
    always_comb begin
        state_n   = state;
        tos_n     = tos;
        depth_n   = depth;
        ram_we    = 1'b0;
        ram_addr  = AW'(depth_m2);
        ram_wdata = tos;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        case (state)
            ST_POP_RD: begin
                tos_n   = ram_rdata;
                depth_n = depth_m1;
                state_n = ST_IDLE;
            end
            ST_SWAP_RD: begin
                ram_we  = 1'b1;
                tos_n   = ram_rdata;
                state_n = ST_IDLE;
            end
            default: begin
                if (fire) begin
                    case (cmd_op)
                        OP_PUSH: begin
                            if (full) begin
                                set_ovf = 1'b1;
                            end else begin
                                if (!empty) begin
                                    ram_we   = 1'b1;
                                    ram_addr = AW'(depth_m1);
                                end
                                tos_n   = cmd_data;
                                depth_n = depth + DW'(1);
                            end
                        end
                        OP_POP: begin
                            if (empty) begin
                                set_unf = 1'b1;
                            end else if (!nos_ok) begin
                                tos_n   = '0;
                                depth_n = '0;
                            end else begin
                                state_n = ST_POP_RD;
                            end
                        end
                        OP_DUP: begin
                            if (empty) begin
                                set_unf = 1'b1;
                            end else if (full) begin
                                set_ovf = 1'b1;
                            end else begin
                                ram_we   = 1'b1;
                                ram_addr = AW'(depth_m1);
                                depth_n  = depth + DW'(1);
                            end
                        end
                        OP_SWAP: begin
                            if (!nos_ok) begin
                                set_unf = 1'b1;
                            end else begin
                                state_n = ST_SWAP_RD;
                            end
                        end
                        OP_REPLACE: begin
                            if (empty) begin
                                set_unf = 1'b1;
                            end else begin
                                tos_n = cmd_data;
                            end
                        end
                        OP_NOP:  ;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ST_IDLE;
            tos           <= '0;
            depth         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state         <= state_n;
            tos           <= tos_n;
            depth         <= depth_n;
            err_overflow  <= set_ovf | (err_overflow & ~err_clr);
            err_underflow <= set_unf | (err_underflow & ~err_clr);
        end
    end

`ifdef DATA_STACK_HWM_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hwm <= '0;
        end else if (depth_n > hwm) begin
            hwm <= depth_n;
        end
    end
`else
    assign hwm = '0;
`endif

endmodule
